mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
// CPU-side initiator for the word-organised data memory (DMEM: async read, 1-cycle write, word index = addr[15:2]).
// Sits between the pipeline MEM stage and DMEM. Turns byte/half/word loads and stores into DMEM word accesses.
// Sub-word stores are done as read-modify-write, because DMEM has no byte enables.
// Provides a valid/ready request side and a single-cycle response pulse, so the pipeline stalls while busy.
// PARAMETERS
// BASE_ADDR  32'h0000_0000  subtracted from req_addr before it drives dmem_addr
// PORTS
// clk          in   1   system clock; all state changes on rising edge
// rst          in   1   synchronous reset, active-high
// req_valid    in   1   request present
// req_ready    out  1   unit idle and able to accept a request
// req_we       in   1   1=store, 0=load
// req_size     in   2   00=byte, 01=half, 10/11=word
// req_unsigned in   1   loads only: 1=zero-extend, 0=sign-extend
// req_addr     in   32  byte address
// req_wdata    in   32  store data, right-justified
// resp_valid   out  1   one-cycle pulse: request completed
// resp_rdata   out  32  extended load data; 0 for stores; held until next resp_valid
// resp_err     out  1   misaligned-access flag, valid with resp_valid (constant 0 without MISALIGN_TRAP_EN)
// dmem_addr    out  32  byte address to DMEM, word-aligned ({x[31:2],2'b00})
// dmem_we      out  1   DMEM write enable
// dmem_wdata   out  32  DMEM write data
// dmem_rdata   in   32  DMEM async read data for dmem_addr
// BEHAVIOUR
// - FSM states: IDLE, ACCESS, MERGE, RESP. req_ready = (state==IDLE).
// - Request capture: a handshake (req_valid & req_ready) latches all req_* fields. Inputs are ignored outside IDLE.
// - IDLE -> ACCESS on handshake.
// - ACCESS, load: latch the extracted and extended value from dmem_rdata -> RESP.
// - ACCESS, word store: dmem_we=1, dmem_wdata=req_wdata -> RESP.
// - ACCESS, byte/half store: latch dmem_rdata as the merge word -> MERGE.
// - MERGE: dmem_we=1, dmem_wdata = merge word with the selected lane(s) replaced by wdata[7:0] / wdata[15:0] -> RESP.
// - RESP: resp_valid=1 for exactly one cycle -> IDLE. No new request is accepted in RESP.
// - Latency, handshake at cycle 0:
//     load / word store: resp_valid in cycle 2.
//     sub-word store: resp_valid in cycle 3.
//   Back-to-back throughput: one request every 3 cycles (4 for sub-word stores).
// - Lanes are little-endian.
//     byte: lane = addr[1:0], data bits [8*lane+7 : 8*lane].
//     half: addr[1]=0 -> bits [15:0]; addr[1]=1 -> bits [31:16].
// - Load extension is taken from the MSB of the selected lane when req_unsigned=0.
// - dmem_addr = {(addr-BASE_ADDR)[31:2],2'b00} in ACCESS and MERGE; 0 otherwise. Address arithmetic wraps modulo 2^32.
// - dmem_we is 0 in IDLE and RESP. It is gated by !rst, so no write occurs in a cycle where rst is high.
// - Reset values: state=IDLE, req_ready=1 from the first cycle after reset, resp_valid=0, resp_rdata=0, resp_err=0,
//   dmem_we=0, dmem_addr=0, dmem_wdata=0.
// - Reset mid-operation: the access is aborted, no response is issued, and a pending RMW write is dropped.
// - Misalignment: half with addr[0]=1, or word with addr[1:0]!=0 (the "misaligned" condition).
// CONFIGURATION
// MISALIGN_TRAP_EN defined:
//   - Misaligned request goes IDLE -> RESP directly (resp_valid in cycle 1).
//   - resp_err=1, resp_rdata=0, and DMEM is not accessed (dmem_we stays 0).
// MISALIGN_TRAP_EN undefined:
//   - resp_err is tied to 0.
//   - Misaligned offset bits are ignored: half uses addr[1] only, word uses addr[31:2].
//   - The access completes normally.
// TESTING
// 1. rst=1 for 2 cycles, then release -> req_ready=1, resp_valid=0, dmem_we=0, dmem_addr=0, resp_rdata=0.
// 2. sw 0xDEADBEEF to 0x10 -> cycle1: dmem_we=1, dmem_addr=0x10, dmem_wdata=0xDEADBEEF. Cycle2: resp_valid=1, resp_rdata=0.
// 3. mem[0x10]=0x80FF1234:
//      lb 0x13 -> resp_rdata=0xFFFFFF80 in cycle 2; lbu 0x13 -> 0x00000080.
//      lh 0x12 -> 0xFFFF80FF; lhu 0x12 -> 0x000080FF.
// 4. mem[0x10]=0x11223344:
//      sb 0xAB to 0x11 -> cycle2: dmem_we=1, wdata=0x1122AB44; resp cycle3.
//      sh 0xBEEF to 0x12 -> 0xBEEF3344.
// 5. lh 0x11 with mem[0x10]=0x11223344:
//      with MISALIGN_TRAP_EN -> resp_valid and resp_err=1 in cycle 1, rdata=0, no dmem access.
//      without it -> rdata=0x00003344 in cycle 2.
// 6. sb in progress, rst=1 during the MERGE cycle -> dmem_we=0, no resp_valid, req_ready=1 the next cycle, memory unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit: converts byte/half/word loads and stores into word accesses on DMEM,
// using read-modify-write for sub-word stores. Optional feature macro: MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    // req_ready is high only when idle; resp_valid is a single-cycle completion pulse.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_MERGE  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;

    logic        handshake;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic [31:0] off_addr;
    logic        word_store;
    logic        unused_off_bits;

    assign handshake  = req_valid && (state_q == S_IDLE);
    assign word_store = we_q && size_q[1];

    always_comb begin
        lane_b = 8'h00;
        case (addr_q[1:0])
            2'd0:    lane_b = dmem_rdata[7:0];
            2'd1:    lane_b = dmem_rdata[15:8];
            2'd2:    lane_b = dmem_rdata[23:16];
            default: lane_b = dmem_rdata[31:24];
        endcase
    end

    // addr_q[0] never selects a half lane; misaligned halves fold onto the aligned one.
    assign lane_h = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_ext = dmem_rdata;
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        merged = merge_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic err_q, err_d;
    logic req_misaligned;

    assign req_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                            (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
`ifdef MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = S_ACCESS;
`ifdef MISALIGN_TRAP_EN
                    err_d   = 1'b0;
                    // Trapped accesses never touch DMEM and respond one cycle early.
                    if (req_misaligned) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                        state_d = S_RESP;
                    end
`endif
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    rdata_d = load_ext;
                    state_d = S_RESP;
                end else if (size_q[1]) begin
                    rdata_d = 32'h0;
                    state_d = S_RESP;
                end else begin
                    merge_d = dmem_rdata;
                    state_d = S_MERGE;
                end
            end
            S_MERGE: begin
                rdata_d = 32'h0;
                state_d = S_RESP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
`ifdef MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    assign off_addr        = addr_q - BASE_ADDR;
    assign unused_off_bits = ^off_addr[1:0];

    always_comb begin
        dmem_addr  = 32'h0;
        dmem_we    = 1'b0;
        dmem_wdata = 32'h0;
        if ((state_q == S_ACCESS) || (state_q == S_MERGE)) begin
            dmem_addr = {off_addr[31:2], 2'b00};
        end
        // Writes are suppressed while rst is high so an aborted RMW leaves memory untouched.
        if ((state_q == S_ACCESS) && word_store) begin
            dmem_we    = !rst;
            dmem_wdata = wdata_q;
        end else if (state_q == S_MERGE) begin
            dmem_we    = !rst;
            dmem_wdata = merged;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_RESP);
    assign resp_rdata  = rdata_q;
    assign dbg_state_o = state_q;
`ifdef MISALIGN_TRAP_EN
    assign resp_err    = err_q;
`else
    assign resp_err    = 1'b0;
`endif

endmodule
